tube_collision_judge: RTL and testbench

//  Consumes the eight tube rectangles produced by the tube location combiner
//  (four lower, four upper "_U") plus the bird position, once per clk_100hz tick.

---
 rtl/flappy_pkg.sv | 16 +
 rtl/rect_overlap.sv | 22 ++
 rtl/tube_collision_judge.sv | 167 ++++++++++++++++
 tb/tb_tube_collision_judge.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// flappy_pkg: game state encoding, screen constants and default bird size
package flappy_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DEAD = 2'd2} game_state_t;

    localparam int FLOOR_V_DEF = 460;
    localparam int CEIL_V_DEF  = 0;
    localparam int BIRD_W_DEF  = 16;
    localparam int BIRD_SZ_DEF = 16;
    localparam int SCORE_W_DEF = 8;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/rect_overlap.sv
// rect_overlap: strict 11-bit overlap test of two [h,h+w) x [v,v+ht) rectangles
module rect_overlap (
    input  logic [9:0] ah,
    input  logic [9:0] av,
    input  logic [9:0] aw,
    input  logic [9:0] aht,
    input  logic [9:0] bh,
    input  logic [9:0] bv,
    input  logic [9:0] bw,
    input  logic [9:0] bht,
    output logic       hit
);

    // zero-size rectangles are placeholders and must never collide
    logic nonzero, x_ov, y_ov;

    assign nonzero = (aw != '0) && (aht != '0) && (bw != '0) && (bht != '0);
    assign x_ov    = ({1'b0, ah} < {1'b0, bh} + {1'b0, bw}) && ({1'b0, bh} < {1'b0, ah} + {1'b0, aw});
    assign y_ov    = ({1'b0, av} < {1'b0, bv} + {1'b0, bht}) && ({1'b0, bv} < {1'b0, av} + {1'b0, aht});
    assign hit     = nonzero && x_ov && y_ov;

endmodule

// File: rtl/tube_collision_judge.sv
// tube_collision_judge: bird/tube/floor/ceiling hit detection, scoring and game FSM
// Optional best_score register enabled by defining HIGH_SCORE_EN.
import flappy_pkg::*;

module tube_collision_judge #(
    parameter int BIRD_W  = BIRD_W_DEF,
    parameter int BIRD_SZ = BIRD_SZ_DEF,
    parameter int FLOOR_V = FLOOR_V_DEF,
    parameter int CEIL_V  = CEIL_V_DEF,
    parameter int SCORE_W = SCORE_W_DEF
) (
    input  logic               clk_100hz,
    input  logic               rst,
    input  logic               start,
    input  logic [9:0]         bird_h,
    input  logic [9:0]         bird_v,
    input  logic [9:0]         tube_h_0,
    input  logic [9:0]         tube_h_1,
    input  logic [9:0]         tube_h_2,
    input  logic [9:0]         tube_h_3,
    input  logic [9:0]         tube_h_0_U,
    input  logic [9:0]         tube_h_1_U,
    input  logic [9:0]         tube_h_2_U,
    input  logic [9:0]         tube_h_3_U,
    input  logic [9:0]         tube_v_0,
    input  logic [9:0]         tube_v_1,
    input  logic [9:0]         tube_v_2,
    input  logic [9:0]         tube_v_3,
    input  logic [9:0]         tube_v_0_U,
    input  logic [9:0]         tube_v_1_U,
    input  logic [9:0]         tube_v_2_U,
    input  logic [9:0]         tube_v_3_U,
    input  logic [9:0]         tube_height_0,
    input  logic [9:0]         tube_height_1,
    input  logic [9:0]         tube_height_2,
    input  logic [9:0]         tube_height_3,
    input  logic [9:0]         tube_height_0_U,
    input  logic [9:0]         tube_height_1_U,
    input  logic [9:0]         tube_height_2_U,
    input  logic [9:0]         tube_height_3_U,
    input  logic [9:0]         tube_width_0,
    input  logic [9:0]         tube_width_1,
    input  logic [9:0]         tube_width_2,
    input  logic [9:0]         tube_width_3,
    input  logic [9:0]         tube_width_0_U,
    input  logic [9:0]         tube_width_1_U,
    input  logic [9:0]         tube_width_2_U,
    input  logic [9:0]         tube_width_3_U,
`ifdef HIGH_SCORE_EN
    output logic [SCORE_W-1:0] best_score,
`endif
    output logic [1:0]         game_state,
    output logic               hit_pulse,
    output logic [SCORE_W-1:0] score,
    output logic               score_pulse
);

    logic [9:0] th [8];
    logic [9:0] tv [8];
    logic [9:0] tht [8];
    logic [9:0] tw [8];

    assign th  = '{tube_h_0, tube_h_1, tube_h_2, tube_h_3,
                   tube_h_0_U, tube_h_1_U, tube_h_2_U, tube_h_3_U};
    assign tv  = '{tube_v_0, tube_v_1, tube_v_2, tube_v_3,
                   tube_v_0_U, tube_v_1_U, tube_v_2_U, tube_v_3_U};
    assign tht = '{tube_height_0, tube_height_1, tube_height_2, tube_height_3,
                   tube_height_0_U, tube_height_1_U, tube_height_2_U, tube_height_3_U};
    assign tw  = '{tube_width_0, tube_width_1, tube_width_2, tube_width_3,
                   tube_width_0_U, tube_width_1_U, tube_width_2_U, tube_width_3_U};

    logic [7:0] ov;

    for (genvar g = 0; g < 8; g++) begin : g_ov
        rect_overlap u_ov (
            .ah (bird_h),
            .av (bird_v),
            .aw (10'(BIRD_W)),
            .aht(10'(BIRD_SZ)),
            .bh (th[g]),
            .bv (tv[g]),
            .bw (tw[g]),
            .bht(tht[g]),
            .hit(ov[g])
        );
    end

    logic hit_now, hit_r;

    assign hit_now = (|ov) || ({1'b0, bird_v} + 11'(BIRD_SZ) >= 11'(FLOOR_V)) || (bird_v <= 10'(CEIL_V));

    // a lower tube counts as passed once its right edge is at or left of the bird's left edge
    logic [3:0] pass_now, passed, passed_n;

    for (genvar i = 0; i < 4; i++) begin : g_pass
        assign pass_now[i] = {1'b0, th[i]} + {1'b0, tw[i]} <= {1'b0, bird_h};
    end

    logic [2:0]         cnt;
    logic [SCORE_W:0]   sum;
    logic [SCORE_W-1:0] score_sat, score_n;

    assign cnt       = popcount4(pass_now & ~passed);
    assign sum       = {1'b0, score} + (SCORE_W + 1)'(cnt);
    assign score_sat = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];

    game_state_t state, state_n;
    logic        hit_n, pulse_n;

    always_comb begin
        state_n  = state;
        score_n  = score;
        passed_n = passed;
        hit_n    = 1'b0;
        pulse_n  = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_n  = PLAY;
                score_n  = '0;
                passed_n = '0;
            end
            PLAY: if (hit_r) begin
                state_n = DEAD;
                hit_n   = 1'b1;
            end else begin
                passed_n = pass_now;
                score_n  = score_sat;
                pulse_n  = cnt != '0;
            end
            DEAD: if (start) begin
                state_n = PLAY;
                score_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_100hz) begin
        if (rst) begin
            state       <= IDLE;
            hit_r       <= 1'b0;
            hit_pulse   <= 1'b0;
            score       <= '0;
            score_pulse <= 1'b0;
            passed      <= '0;
        end else begin
            state       <= state_n;
            hit_r       <= hit_now;
            hit_pulse   <= hit_n;
            score       <= score_n;
            score_pulse <= pulse_n;
            passed      <= passed_n;
        end
    end

`ifdef HIGH_SCORE_EN
    always_ff @(posedge clk_100hz) begin
        if (rst)
            best_score <= '0;
        else if (hit_n && score > best_score)
            best_score <= score;
    end
`endif

    assign game_state = state;

endmodule

// File: tb/tb_tube_collision_judge.sv
// tb_tube_collision_judge: directed self-checking bench for tube_collision_judge
// Exercises best_score as well when HIGH_SCORE_EN is defined.
module tb_tube_collision_judge;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [9:0] bird_h, bird_v;
    logic [9:0] th [8];
    logic [9:0] tv [8];
    logic [9:0] tht [8];
    logic [9:0] tw [8];
    logic [1:0] game_state;
    logic       hit_pulse, score_pulse;
    logic [7:0] score;
`ifdef HIGH_SCORE_EN
    logic [7:0] best_score;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tube_collision_judge dut (
        .clk_100hz(clk), .rst(rst), .start(start), .bird_h(bird_h), .bird_v(bird_v),
        .tube_h_0(th[0]), .tube_h_1(th[1]), .tube_h_2(th[2]), .tube_h_3(th[3]),
        .tube_h_0_U(th[4]), .tube_h_1_U(th[5]), .tube_h_2_U(th[6]), .tube_h_3_U(th[7]),
        .tube_v_0(tv[0]), .tube_v_1(tv[1]), .tube_v_2(tv[2]), .tube_v_3(tv[3]),
        .tube_v_0_U(tv[4]), .tube_v_1_U(tv[5]), .tube_v_2_U(tv[6]), .tube_v_3_U(tv[7]),
        .tube_height_0(tht[0]), .tube_height_1(tht[1]), .tube_height_2(tht[2]), .tube_height_3(tht[3]),
        .tube_height_0_U(tht[4]), .tube_height_1_U(tht[5]), .tube_height_2_U(tht[6]), .tube_height_3_U(tht[7]),
        .tube_width_0(tw[0]), .tube_width_1(tw[1]), .tube_width_2(tw[2]), .tube_width_3(tw[3]),
        .tube_width_0_U(tw[4]), .tube_width_1_U(tw[5]), .tube_width_2_U(tw[6]), .tube_width_3_U(tw[7]),
`ifdef HIGH_SCORE_EN
        .best_score(best_score),
`endif
        .game_state(game_state), .hit_pulse(hit_pulse), .score(score), .score_pulse(score_pulse)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lower tubes occupy y [300,460), upper [0,150); the bird at y 200..215 sits in the gap
    task automatic park_tubes();
        for (int i = 0; i < 8; i++) begin
            th[i]  = 10'd600;
            tw[i]  = 10'd40;
            tv[i]  = (i < 4) ? 10'd300 : 10'd0;
            tht[i] = (i < 4) ? 10'd160 : 10'd150;
        end
        bird_h = 10'd100;
        bird_v = 10'd200;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic die();
        bird_v = 10'd450;
        tick();
        bird_v = 10'd200;
        tick();
    endtask

    task automatic test_reset();
        park_tubes();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (game_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", game_state); end
        checks++; if (score !== 8'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", score); end
        checks++; if (hit_pulse !== 1'b0 || score_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", hit_pulse, score_pulse); end
        bird_v = 10'd450;
        tick();
        tick();
        bird_v = 10'd200;
        tick();
        checks++; if (game_state !== 2'd0 || hit_pulse !== 1'b0) begin failures++; $display("FAIL idle_ignores_hit got=%0d/%b exp=0/0", game_state, hit_pulse); end
    endtask

    task automatic test_start_quiet();
        bit bad = 0;
        pulse_start();
        checks++; if (game_state !== 2'd1 || score !== 8'd0) begin failures++; $display("FAIL start_play got=%0d/%0d exp=1/0", game_state, score); end
        for (int i = 0; i < 100; i++) begin
            tick();
            if (game_state !== 2'd1 || hit_pulse !== 1'b0 || score_pulse !== 1'b0) bad = 1;
        end
        checks++; if (bad) begin failures++; $display("FAIL quiet_play got=%0d exp=1", game_state); end
    endtask

    task automatic test_score_sweep();
        int pulses = 0;
        for (int h = 130; h >= 60; h--) begin
            th[0] = 10'(h);
            tick();
            if (score_pulse) pulses++;
            if (h == 61) begin
                checks++; if (score !== 8'd0) begin failures++; $display("FAIL sweep_before got=%0d exp=0", score); end
            end
        end
        checks++; if (score !== 8'd1 || score_pulse !== 1'b1) begin failures++; $display("FAIL sweep_edge got=%0d/%b exp=1/1", score, score_pulse); end
        tick();
        tick();
        if (score_pulse) pulses++;
        checks++; if (score !== 8'd1 || pulses !== 1) begin failures++; $display("FAIL sweep_once got=%0d/%0d exp=1/1", score, pulses); end
        pulse_start();
        checks++; if (game_state !== 2'd1 || score !== 8'd1) begin failures++; $display("FAIL start_in_play got=%0d/%0d exp=1/1", game_state, score); end
        th[0] = 10'd600;
        tick();
        th[0] = 10'd60;
        tick();
        checks++; if (score !== 8'd2 || score_pulse !== 1'b1) begin failures++; $display("FAIL rearm got=%0d/%b exp=2/1", score, score_pulse); end
        th[0] = 10'd600;
        tick();
    endtask

    task automatic test_tube_hit();
        th[4] = 10'd110;
        tht[4] = 10'd210;
        tw[4] = 10'd0;
        tick();
        tick();
        checks++; if (game_state !== 2'd1) begin failures++; $display("FAIL zero_width got=%0d exp=1", game_state); end
        th[4] = 10'd116;
        tw[4] = 10'd40;
        tick();
        tick();
        checks++; if (game_state !== 2'd1) begin failures++; $display("FAIL touching_edge got=%0d exp=1", game_state); end
        th[4] = 10'd110;
        tick();
        checks++; if (game_state !== 2'd1 || hit_pulse !== 1'b0) begin failures++; $display("FAIL hit_latency got=%0d/%b exp=1/0", game_state, hit_pulse); end
        tick();
        checks++; if (game_state !== 2'd2 || hit_pulse !== 1'b1) begin failures++; $display("FAIL tube_hit got=%0d/%b exp=2/1", game_state, hit_pulse); end
        park_tubes();
        tick();
        checks++; if (game_state !== 2'd2 || hit_pulse !== 1'b0 || score !== 8'd2) begin failures++; $display("FAIL dead_hold got=%0d/%b/%0d exp=2/0/2", game_state, hit_pulse, score); end
    endtask

    task automatic test_floor_ceiling();
        pulse_start();
        checks++; if (game_state !== 2'd1 || score !== 8'd0) begin failures++; $display("FAIL restart got=%0d/%0d exp=1/0", game_state, score); end
        bird_v = 10'd443;
        tick();
        tick();
        checks++; if (game_state !== 2'd1) begin failures++; $display("FAIL floor_clear got=%0d exp=1", game_state); end
        bird_v = 10'd444;
        tick();
        bird_v = 10'd200;
        tick();
        checks++; if (game_state !== 2'd2 || hit_pulse !== 1'b1) begin failures++; $display("FAIL floor_hit got=%0d/%b exp=2/1", game_state, hit_pulse); end
        pulse_start();
        bird_v = 10'd1;
        tick();
        tick();
        checks++; if (game_state !== 2'd1) begin failures++; $display("FAIL ceil_clear got=%0d exp=1", game_state); end
        bird_v = 10'd0;
        tick();
        bird_v = 10'd200;
        tick();
        checks++; if (game_state !== 2'd2) begin failures++; $display("FAIL ceil_hit got=%0d exp=2", game_state); end
    endtask

    task automatic test_saturation();
        pulse_start();
        for (int i = 0; i < 254; i++) begin
            th[0] = 10'd60;
            tick();
            th[0] = 10'd600;
            tick();
        end
        checks++; if (score !== 8'd254) begin failures++; $display("FAIL score_254 got=%0d exp=254", score); end
        th[0] = 10'd60;
        th[1] = 10'd60;
        tick();
        checks++; if (score !== 8'd255 || score_pulse !== 1'b1) begin failures++; $display("FAIL double_sat got=%0d/%b exp=255/1", score, score_pulse); end
        th[0] = 10'd600;
        th[1] = 10'd600;
        tick();
        th[0] = 10'd60;
        tick();
        checks++; if (score !== 8'd255 || score_pulse !== 1'b1) begin failures++; $display("FAIL hold_sat got=%0d/%b exp=255/1", score, score_pulse); end
        th[0] = 10'd600;
        die();
    endtask

    task automatic test_hit_beats_pass();
        park_tubes();
        pulse_start();
        checks++; if (game_state !== 2'd1 || score !== 8'd0) begin failures++; $display("FAIL hbp_start got=%0d/%0d exp=1/0", game_state, score); end
        bird_v = 10'd450;
        tick();
        checks++; if (game_state !== 2'd1) begin failures++; $display("FAIL hbp_arm got=%0d exp=1", game_state); end
        bird_v = 10'd200;
        th[0] = 10'd60;
        th[1] = 10'd60;
        tick();
        checks++; if (game_state !== 2'd2 || hit_pulse !== 1'b1 || score !== 8'd0 || score_pulse !== 1'b0) begin
            failures++; $display("FAIL hit_beats_pass got=%0d/%b/%0d/%b exp=2/1/0/0", game_state, hit_pulse, score, score_pulse);
        end
        park_tubes();
        tick();
    endtask

`ifdef HIGH_SCORE_EN
    task automatic play_to(input int n);
        pulse_start();
        for (int i = 0; i < n; i++) begin
            th[0] = 10'd60;
            tick();
            th[0] = 10'd600;
            tick();
        end
        die();
    endtask

    task automatic test_high_score();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (best_score !== 8'd0) begin failures++; $display("FAIL best_reset got=%0d exp=0", best_score); end
        play_to(5);
        checks++; if (best_score !== 8'd5) begin failures++; $display("FAIL best_first got=%0d exp=5", best_score); end
        play_to(3);
        checks++; if (best_score !== 8'd5 || score !== 8'd3) begin failures++; $display("FAIL best_keep got=%0d/%0d exp=5/3", best_score, score); end
        pulse_start();
        th[0] = 10'd60;
        tick();
        th[0] = 10'd600;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (game_state !== 2'd0 || score !== 8'd0 || best_score !== 8'd0) begin
            failures++; $display("FAIL rst_mid_play got=%0d/%0d/%0d exp=0/0/0", game_state, score, best_score);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_start_quiet();
        test_score_sweep();
        test_tube_hit();
        test_floor_ceiling();
        test_saturation();
        test_hit_beats_pass();
`ifdef HIGH_SCORE_EN
        test_high_score();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
